// File: rtl/audio_i2s_port_pkg.sv
// Shared constants and types for the codec-side I2S audio port.
package audio_pkg;
    localparam int WIDTH_DEFAULT = 24;
    localparam int DEPTH_DEFAULT = 8;
    // Rising BCLK edges between an LRCK transition and the MSB.
    localparam int I2S_DELAY     = 1;

    // LRCK level selects the slot: low = left, high = right.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;
endpackage

// File: rtl/audio_i2s_port_if.sv
// Sample handshake between the audio port and the user datapath.
interface audio_i2s_port_if #(
    parameter int WIDTH = audio_pkg::WIDTH_DEFAULT
);
    logic             read;
    logic             write;
    logic [WIDTH-1:0] writedata_left;
    logic [WIDTH-1:0] writedata_right;
    logic [WIDTH-1:0] readdata_left;
    logic [WIDTH-1:0] readdata_right;
    logic             read_ready;
    logic             write_ready;

    // User logic side.
    modport master (
        output read, write, writedata_left, writedata_right,
        input  readdata_left, readdata_right, read_ready, write_ready
    );

    // Audio port side.
    modport slave (
        input  read, write, writedata_left, writedata_right,
        output readdata_left, readdata_right, read_ready, write_ready
    );
endinterface

// File: rtl/audio_i2s_port_sample_fifo.sv
// Show-ahead FIFO of left/right sample pairs; head reads as zero when empty.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 48
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents are don't-care until counted in.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/audio_i2s_port.sv
// WM8731 I2S endpoint: deserializes ADC pairs into one FIFO, serializes
// DAC pairs from another. BCLK/LRCK are codec-driven and oversampled.
module audio_i2s_port
    import audio_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            AUD_BCLK,
    input  logic            AUD_ADCLRCK,
    input  logic            AUD_DACLRCK,
    input  logic            AUD_ADCDAT,
    output logic            AUD_DACDAT,
    audio_i2s_port_if.slave bus
);
    localparam int P_BCLK = 0;
    localparam int P_ALR  = 1;
    localparam int P_DLR  = 2;
    localparam int P_ADAT = 3;

    localparam int                RX_CW    = $clog2(I2S_DELAY + WIDTH + 1);
    localparam logic [RX_CW-1:0]  RX_FIRST = RX_CW'(I2S_DELAY);
    localparam logic [RX_CW-1:0]  RX_LAST  = RX_CW'(I2S_DELAY + WIDTH - 1);
    localparam int                TX_CW    = $clog2(WIDTH + 1);
    localparam logic [TX_CW-1:0]  TX_LAST  = TX_CW'(WIDTH);

    logic [3:0]         w_pins;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_hist;
    logic               w_bclk_rise;
    logic               w_bclk_fall;
    logic               w_adc_lr_edge;
    logic               w_dac_lr_fall;
    logic               w_dac_lr_rise;
    logic               w_adc_bit;

    logic               r_rx_active;
    logic [RX_CW-1:0]   r_rx_cnt;
    logic [WIDTH-1:0]   r_rx_shift;
    channel_t           r_rx_chan;
    logic [WIDTH-1:0]   r_left_hold;
    logic               r_left_valid;
    logic [WIDTH-1:0]   w_rx_word;
    logic               w_rx_done;
    logic               w_rx_push;

    logic [TX_CW-1:0]   r_tx_cnt;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_tx_right;
    logic               r_tx_bit;
    logic               r_dacdat;

    logic [2*WIDTH-1:0] w_adc_head;
    logic               w_adc_full;
    logic               w_adc_empty;
    logic [2*WIDTH-1:0] w_dac_head;
    logic               w_dac_full;
    logic               w_dac_empty;

    assign w_pins = {AUD_ADCDAT, AUD_DACLRCK, AUD_ADCLRCK, AUD_BCLK};

    // Two-flop synchronizers plus edge history. Left out of reset so a
    // mid-frame reset does not fabricate LRCK edges from stale history.
    always_ff @(posedge CLOCK_50) begin
        r_sync1 <= w_pins;
        r_sync2 <= r_sync1;
        r_hist  <= r_sync2;
    end

    assign w_bclk_rise   =  r_sync2[P_BCLK] & ~r_hist[P_BCLK];
    assign w_bclk_fall   = ~r_sync2[P_BCLK] &  r_hist[P_BCLK];
    assign w_adc_lr_edge =  r_sync2[P_ALR]  ^  r_hist[P_ALR];
    assign w_dac_lr_fall = ~r_sync2[P_DLR]  &  r_hist[P_DLR];
    assign w_dac_lr_rise =  r_sync2[P_DLR]  & ~r_hist[P_DLR];
    // ADCDAT is stable around BCLK rise, so the history copy is safe to use.
    assign w_adc_bit     =  r_hist[P_ADAT];

    assign w_rx_word = {r_rx_shift[WIDTH-2:0], w_adc_bit};
    assign w_rx_done = w_bclk_rise && r_rx_active && !w_adc_lr_edge && (r_rx_cnt == RX_LAST);
    // Only a right word that follows a complete left word forms a pair.
    assign w_rx_push = w_rx_done && (r_rx_chan == RIGHT) && r_left_valid && !w_adc_full;

    // RX deserializer: arm on LRCK edge, skip the delay bit, shift WIDTH bits.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_rx_active  <= 1'b0;
            r_rx_cnt     <= '0;
            r_rx_shift   <= '0;
            r_rx_chan    <= LEFT;
            r_left_hold  <= '0;
            r_left_valid <= 1'b0;
        end else if (w_adc_lr_edge) begin
            r_rx_active <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_shift  <= '0;
            r_rx_chan   <= channel_t'(r_sync2[P_ALR]);
        end else if (w_bclk_rise && r_rx_active && (r_rx_cnt <= RX_LAST)) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_cnt >= RX_FIRST) begin
                r_rx_shift <= w_rx_word;
            end
            if (w_rx_done && (r_rx_chan == LEFT)) begin
                r_left_hold  <= w_rx_word;
                r_left_valid <= 1'b1;
            end else if (w_rx_done) begin
                r_left_valid <= 1'b0;
            end
        end
    end

    // TX serializer: load on LRCK edges, one bit per BCLK fall, then zeros.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_right <= '0;
            r_tx_bit   <= 1'b0;
            r_dacdat   <= 1'b0;
        end else begin
            r_dacdat <= r_tx_bit;
            if (w_dac_lr_fall) begin
                r_tx_cnt   <= '0;
                r_tx_bit   <= 1'b0;
                r_tx_shift <= w_dac_empty ? '0 : w_dac_head[2*WIDTH-1:WIDTH];
                r_tx_right <= w_dac_empty ? '0 : w_dac_head[WIDTH-1:0];
            end else if (w_dac_lr_rise) begin
                r_tx_cnt   <= '0;
                r_tx_bit   <= 1'b0;
                r_tx_shift <= r_tx_right;
            end else if (w_bclk_fall) begin
                if (r_tx_cnt < TX_LAST) begin
                    r_tx_bit   <= r_tx_shift[WIDTH-1];
                    r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                    r_tx_cnt   <= r_tx_cnt + 1'b1;
                end else begin
                    r_tx_bit <= 1'b0;
                end
            end
        end
    end

    assign AUD_DACDAT = r_dacdat;

    sample_fifo #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_adc_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_push  (w_rx_push),
        .i_data  ({r_left_hold, w_rx_word}),
        .i_pop   (bus.read),
        .o_data  (w_adc_head),
        .o_full  (w_adc_full),
        .o_empty (w_adc_empty)
    );

    sample_fifo #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_dac_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_push  (bus.write),
        .i_data  ({bus.writedata_left, bus.writedata_right}),
        .i_pop   (w_dac_lr_fall),
        .o_data  (w_dac_head),
        .o_full  (w_dac_full),
        .o_empty (w_dac_empty)
    );

    assign bus.readdata_left  = w_adc_head[2*WIDTH-1:WIDTH];
    assign bus.readdata_right = w_adc_head[WIDTH-1:0];
    assign bus.read_ready     = !w_adc_empty;
    assign bus.write_ready    = !w_dac_full;
endmodule

// File: tb/tb_audio_i2s_port.sv
// Directed bench for audio_i2s_port: plays the codec side of I2S
// (BCLK = CLOCK_50/16, 32 BCLK per slot) and drives the user handshake.
module tb_audio_i2s_port;
    logic CLOCK_50 = 1'b0;
    logic reset;
    logic AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT;
    logic AUD_DACDAT;
    int   n_cmp = 0;
    int   n_bad = 0;

    audio_i2s_port_if #(.WIDTH(24)) bus ();

    audio_i2s_port #(.DEPTH(8), .WIDTH(24)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .AUD_DACDAT  (AUD_DACDAT),
        .bus         (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One I2S slot, BCLK periods j0..j1. LRCK/ADCDAT change on BCLK fall;
    // DACDAT is sampled on BCLK rise. Bit j=1..24 carries word[24-j].
    task automatic run_slot(input logic lr, input logic [23:0] adc_word,
                            input int j0, input int j1,
                            output logic [23:0] dac_word, output int pad_ones);
        dac_word = '0;
        pad_ones = 0;
        for (int j = j0; j <= j1; j++) begin
            @(negedge CLOCK_50);
            AUD_BCLK    = 1'b0;
            AUD_ADCLRCK = lr;
            AUD_DACLRCK = lr;
            AUD_ADCDAT  = (j >= 1 && j <= 24) ? adc_word[24-j] : 1'b0;
            repeat (8) @(negedge CLOCK_50);
            AUD_BCLK = 1'b1;
            if (j >= 1 && j <= 24) dac_word[24-j] = AUD_DACDAT;
            else pad_ones += int'(AUD_DACDAT);
            repeat (7) @(negedge CLOCK_50);
        end
    endtask

    task automatic run_frame(input logic [23:0] adc_l, input logic [23:0] adc_r,
                             output logic [23:0] dac_l, output logic [23:0] dac_r,
                             output int pad);
        int p0, p1;
        run_slot(1'b0, adc_l, 0, 31, dac_l, p0);
        run_slot(1'b1, adc_r, 0, 31, dac_r, p1);
        pad = p0 + p1;
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        @(negedge CLOCK_50);
        bus.write           = 1'b1;
        bus.writedata_left  = l;
        bus.writedata_right = r;
        @(negedge CLOCK_50);
        bus.write = 1'b0;
    endtask

    task automatic pop_pair();
        @(negedge CLOCK_50);
        bus.read = 1'b1;
        @(negedge CLOCK_50);
        bus.read = 1'b0;
    endtask

    initial begin
        logic [23:0] dl, dr, part;
        int          pad, idle_bad;

        reset = 1'b1;
        AUD_BCLK = 1'b1; AUD_ADCLRCK = 1'b1; AUD_DACLRCK = 1'b1; AUD_ADCDAT = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata_left = '0; bus.writedata_right = '0;
        repeat (10) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);

        check_val("rst_read_ready",  48'(bus.read_ready), 48'd0);
        check_val("rst_write_ready", 48'(bus.write_ready), 48'd1);
        check_val("rst_readdata",    {bus.readdata_left, bus.readdata_right}, 48'd0);
        check_val("rst_dacdat",      48'(AUD_DACDAT), 48'd0);

        // Two frames' worth of idle: nothing must move.
        idle_bad = 0;
        repeat (2048) begin
            @(negedge CLOCK_50);
            if (bus.read_ready !== 1'b0 || bus.write_ready !== 1'b1 || AUD_DACDAT !== 1'b0)
                idle_bad++;
        end
        check_val("idle_flags", 48'(idle_bad), 48'd0);

        // ADC capture of one pair; DAC side has nothing queued yet.
        run_frame(24'hABCDEF, 24'h123456, dl, dr, pad);
        check_val("adc1_ready", 48'(bus.read_ready), 48'd1);
        check_val("adc1_data",  {bus.readdata_left, bus.readdata_right}, 48'hABCDEF_123456);
        check_val("dac_first_zero", {dl, dr}, 48'd0);
        check_val("dac_first_pad",  48'(pad), 48'd0);
        pop_pair();
        check_val("adc1_popped_ready", 48'(bus.read_ready), 48'd0);
        check_val("adc1_popped_data",  {bus.readdata_left, bus.readdata_right}, 48'd0);

        // DAC serialization of one pair.
        push_pair(24'h800001, 24'h7FFFFE);
        run_frame(24'h000000, 24'h000000, dl, dr, pad);
        check_val("dac1_left",  48'(dl), 48'h800001);
        check_val("dac1_right", 48'(dr), 48'h7FFFFE);
        check_val("dac1_pad",   48'(pad), 48'd0);
        check_val("adc_zero_pair", {bus.readdata_left, bus.readdata_right}, 48'd0);
        check_val("adc_zero_ready", 48'(bus.read_ready), 48'd1);
        pop_pair();

        // Fill the DAC FIFO; a 9th write is ignored.
        for (int i = 1; i <= 8; i++) push_pair(24'h100000 | 24'(i), 24'h200000 | 24'(i));
        check_val("dac_full_wr_ready", 48'(bus.write_ready), 48'd0);
        push_pair(24'hDEADBE, 24'hEFCAFE);
        check_val("dac_full_9th", 48'(bus.write_ready), 48'd0);
        run_frame(24'h111111, 24'h222222, dl, dr, pad);
        check_val("dac_pair1", {dl, dr}, 48'h100001_200001);
        check_val("dac_after_pop_ready", 48'(bus.write_ready), 48'd1);
        check_val("adc_pair_111", {bus.readdata_left, bus.readdata_right}, 48'h111111_222222);
        pop_pair();

        // Nine ADC frames without reads; DAC drains pairs 2..8, then zeros.
        for (int k = 1; k <= 9; k++) begin
            run_frame(24'hA00000 | 24'(k), 24'hB00000 | 24'(k), dl, dr, pad);
            if (k <= 7)
                check_val($sformatf("dac_drain_%0d", k), {dl, dr},
                          {24'h100000 | 24'(k + 1), 24'h200000 | 24'(k + 1)});
            else
                check_val($sformatf("dac_underflow_%0d", k), {dl, dr}, 48'd0);
            check_val($sformatf("dac_pad_%0d", k), 48'(pad), 48'd0);
        end
        for (int k = 1; k <= 8; k++) begin
            check_val($sformatf("adc_ovf_ready_%0d", k), 48'(bus.read_ready), 48'd1);
            check_val($sformatf("adc_ovf_data_%0d", k), {bus.readdata_left, bus.readdata_right},
                      {24'hA00000 | 24'(k), 24'hB00000 | 24'(k)});
            pop_pair();
        end
        check_val("adc_ovf_empty", 48'(bus.read_ready), 48'd0);

        // Reset in the middle of a left slot carrying all ones.
        push_pair(24'hFFFFFF, 24'hFFFFFF);
        run_slot(1'b0, 24'hFFFFFF, 0, 11, part, pad);
        check_val("pre_reset_msbs", 48'(part[23:13]), 48'h7FF);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check_val("reset_dacdat", 48'(AUD_DACDAT), 48'd0);
        reset = 1'b0;
        run_slot(1'b0, 24'hFFFFFF, 12, 31, part, pad);
        check_val("post_reset_left_bits", 48'(part), 48'd0);
        check_val("post_reset_left_pad",  48'(pad), 48'd0);
        run_slot(1'b1, 24'hFFFFFF, 0, 31, dr, pad);
        check_val("post_reset_right", 48'(dr), 48'd0);
        check_val("partial_no_push", 48'(bus.read_ready), 48'd0);
        run_frame(24'h13579B, 24'h2468AC, dl, dr, pad);
        check_val("post_reset_dac_zero", {dl, dr}, 48'd0);
        check_val("post_reset_adc", {bus.readdata_left, bus.readdata_right}, 48'h13579B_2468AC);
        check_val("post_reset_ready", 48'(bus.read_ready), 48'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/audio_i2s_port.md
# audio_i2s_port

Codec-side endpoint of the audio sample handshake (`read_ready`/`write_ready`/`read`/`write`, 24-bit left/right words) used by the lab's audio datapaths. Receives I2S serial audio from the codec ADC, buffers left/right pairs for the user logic, and accepts pairs from the user logic to serialize to the codec DAC. Sits between the WM8731 pins and any sample-processing module, all in the `CLOCK_50` domain; BCLK and LRCK are codec-driven and oversampled.

## Interface
- `DEPTH`, 8: entries per FIFO (power of 2, ≥2); one entry = one left/right pair
- `WIDTH`, 24: sample width
- `CLOCK_50` input 1: system clock; all logic on rising edge
- `reset` input 1: synchronous, active-high
- `AUD_BCLK` input 1: codec bit clock, asynchronous, ≤ CLOCK_50/8
- `AUD_ADCLRCK` input 1: ADC frame clock; low = left, high = right
- `AUD_DACLRCK` input 1: DAC frame clock; low = left, high = right
- `AUD_ADCDAT` input 1: ADC serial data
- `AUD_DACDAT` output 1: DAC serial data
- `read` input 1: pop one pair from the ADC FIFO
- `write` input 1: push one pair into the DAC FIFO
- `writedata_left`, `writedata_right` input WIDTH: pair to push
- `readdata_left`, `readdata_right` output WIDTH: head of ADC FIFO (show-ahead)
- `read_ready` output 1: ADC FIFO non-empty
- `write_ready` output 1: DAC FIFO not full

## Operation
- Pin sync: BCLK, both LRCKs, ADCDAT each pass 2 flops, then 1 edge-history flop; rise/fall detects are single-cycle pulses.
- I2S framing: MSB is the bit at the 2nd BCLK rising edge after an LRCK transition (1-bit delay); WIDTH bits, MSB first; further bits in the slot are ignored (RX) or driven 0 (TX).
- RX: per-channel bit counter reset on ADCLRCK edge; on BCLK rise, skip first edge, then shift ADCDAT into a WIDTH shift register for WIDTH edges. Left word completes → latch into left holding register. Right word completes → push {left hold, right} into ADC FIFO; if full, the pair is dropped, FIFO unchanged.
- TX: on DACLRCK fall (left slot start), pop DAC FIFO into left/right TX registers; if empty, load zeros (underflow, no stall). On DACLRCK rise, load right TX register into the shift register. On each BCLK fall after an LRCK edge, shift one bit onto `AUD_DACDAT`: first fall drives MSB, WIDTH falls total, then 0 until next LRCK edge.
- Handshake: `write` with `write_ready`=1 pushes on that edge; `write` with `write_ready`=0 ignored. `read` with `read_ready`=1 pops; ignored when 0. `readdata_*` = 0 when empty.
- Simultaneous push and pop on one FIFO in the same cycle: both performed, count unchanged. RX push and user pop, and user push and TX pop, are legal together.

## Timing
- After a reset edge: both FIFOs empty, `read_ready`=0, `write_ready`=1, `readdata_*`=0, `AUD_DACDAT`=0, counters and shift registers 0, holding register 0.
- Reset mid-frame: any partial word discarded; RX and TX resume at the next LRCK edge; first TX frame after reset is zeros unless data was written before that DACLRCK fall.
- Pin-to-internal latency: 3 cycles. `AUD_DACDAT` changes 4 cycles after the BCLK falling pin edge (3 sync + 1 output register).
- `read_ready` rises the cycle after the right word's last bit is captured. Pop effect visible next cycle. `write_ready` and `read_ready` derive from registered counts (no combinational path from `read`/`write`).
- Counts are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

## Structure
- Package `audio_pkg`: WIDTH default, `I2S_DELAY`=1, the channel enum (LEFT=0, RIGHT=1).
- Sub-module `sample_fifo` (DEPTH × 2·WIDTH, show-ahead, full/empty/count), instantiated twice. Sync/edge detect, RX deserializer, TX serializer live in the top.

## Test plan
- Reset then idle: `read_ready`=0, `write_ready`=1, `AUD_DACDAT`=0 for 2 full frames (BCLK = CLOCK_50/16, 32 BCLK per slot).
- ADC drives left 0xABCDEF, right 0x123456 → one frame later `read_ready`=1, `readdata_left`=0xABCDEF, `readdata_right`=0x123456; `read` pulse → `read_ready`=0.
- Write pair (0x800001, 0x7FFFFE) → next DAC frame serializes exactly those bits MSB-first, 1-bit delay, zeros in bits 25–32.
- Write 8 pairs with no frames → `write_ready`=0; 9th write ignored; after one DAC frame, the 1st pair is transmitted and `write_ready`=1.
- 9 ADC frames with no reads → FIFO holds frames 1–8; frame 9 dropped; reads return frames 1–8 in order.
- Assert `reset` mid-left-slot while transmitting 0xFFFFFF → `AUD_DACDAT`=0 immediately after reset edge; next frame zeros; no pair pushed from the partial ADC frame.
